// File: rtl/tis_pkg.sv
// Shared constants and types for the fetch stage and op_decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: PC/opcode widths, pc_instr encodings, fetch FSM states and the
// next-PC helper used by pc_fetch.
package tis_pkg;

    localparam int PC_WIDTH   = 4;
    localparam int OP_WIDTH   = 21;
    localparam int PROG_SLOTS = 16;
    localparam int VAL_WIDTH  = 11;

    typedef enum logic [3:0] {
        PC_NEXT = 4'd0,
        PC_JMP  = 4'd1,
        PC_JEZ  = 4'd2,
        PC_JNZ  = 4'd3,
        PC_JGZ  = 4'd4,
        PC_JLZ  = 4'd5,
        PC_JRO  = 4'd6
    } pc_instr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } fetch_state_e;

    // Next PC for one executed instruction. Encodings outside 0..6 fall back
    // to sequential flow. Absolute targets past the program end restart at 0;
    // relative jumps saturate at the program boundaries instead of wrapping.
    function automatic logic [PC_WIDTH-1:0] calc_pc_next(
        input logic [PC_WIDTH-1:0]         pc,
        input logic [PC_WIDTH-1:0]         last,
        input logic [3:0]                  instr,
        input logic [PC_WIDTH-1:0]         target,
        input logic signed [VAL_WIDTH-1:0] ofs,
        input logic signed [VAL_WIDTH-1:0] acc
    );
        logic [PC_WIDTH-1:0] seq_pc;
        logic [PC_WIDTH-1:0] jmp_pc;
        logic [PC_WIDTH-1:0] res;
        logic signed [11:0]  sum;
        logic                take;

        seq_pc = (pc == last) ? '0 : pc + 4'd1;
        jmp_pc = (target > last) ? '0 : target;
        // 12-bit signed sum: zero-extended pc plus sign-extended offset
        sum    = $signed({8'd0, pc}) + $signed({ofs[VAL_WIDTH-1], ofs});
        take   = 1'b0;
        res    = seq_pc;

        case (instr)
            PC_JMP: take = 1'b1;
            PC_JEZ: take = (acc == 0);
            PC_JNZ: take = (acc != 0);
            PC_JGZ: take = (acc > 0);
            PC_JLZ: take = (acc < 0);
            default: take = 1'b0;
        endcase

        if (instr == PC_JRO) begin
            if (sum < 0) begin
                res = '0;
            end else if (sum > $signed({8'd0, last})) begin
                res = last;
            end else begin
                res = sum[PC_WIDTH-1:0];
            end
        end else if (take) begin
            res = jmp_pc;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_fetch_prog_mem.sv
// Program store: 16x21 array, one synchronous write port, one registered read port.
// Latency: rd_data valid one clk after rd_en/rd_addr; writes land on the same edge.
// Backpressure: none; rd_en low holds rd_data (used as the fetch stall).
// Ports: clk/rst_n; wr_en, wr_addr, wr_data; rd_en, rd_addr, rd_data.
module prog_mem
    import tis_pkg::*;
#(
    parameter int DEPTH = PROG_SLOTS,
    parameter int AW    = PC_WIDTH,
    parameter int DW    = OP_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // Array has no reset: contents survive rst_n and are undefined at power-up.
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for a TIS-style node.
// Latency: op_code equals mem[pc] on the same cycle (1-cycle fetch); first op 2 clks after run.
// Backpressure: stall=1 freezes pc/op_code; run=0 aborts to IDLE with op_valid dropped.
// Ports: clk/rst_n; run; program load (prog_we/addr/data/len); decoder control
// (pc_instr, jmp_target, jro_offset, acc, stall); outputs pc, op_code, op_valid.
module pc_fetch
    import tis_pkg::*;
#(
    parameter int PROG_DEPTH = PROG_SLOTS,
    parameter int OP_W       = OP_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        prog_we,
    input  logic [PC_WIDTH-1:0]         prog_addr,
    input  logic [OP_W-1:0]             prog_data,
    input  logic [PC_WIDTH:0]           prog_len,
    input  logic [3:0]                  pc_instr,
    input  logic [PC_WIDTH-1:0]         jmp_target,
    input  logic signed [VAL_WIDTH-1:0] jro_offset,
    input  logic signed [VAL_WIDTH-1:0] acc,
    input  logic                        stall,
    output logic [PC_WIDTH-1:0]         pc,
    output logic [OP_W-1:0]             op_code,
    output logic                        op_valid
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] last_q, last_d;
    logic                op_valid_q, op_valid_d;
    logic [PC_WIDTH-1:0] pc_next;
    logic                mem_we;
    logic                mem_re;
    logic [PC_WIDTH-1:0] mem_raddr;

    assign pc_next = calc_pc_next(pc_q, last_q, pc_instr, jmp_target, jro_offset, acc);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        last_d     = last_q;
        op_valid_d = op_valid_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_raddr  = pc_next;

        case (state_q)
            ST_IDLE: begin
                pc_d       = '0;
                op_valid_d = 1'b0;
                last_d     = PC_WIDTH'(prog_len - 5'd1);
                // Program memory is only writable from IDLE with run low.
                mem_we     = prog_we & ~run;
                if (run && (prog_len != '0)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d    = ST_RUN;
                pc_d       = '0;
                op_valid_d = 1'b1;
                mem_re     = 1'b1;
                mem_raddr  = '0;
            end
            ST_RUN: begin
                // pc and the memory read address advance together so op_code
                // always tracks mem[pc].
                if (!stall) begin
                    pc_d   = pc_next;
                    mem_re = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping run aborts from any state; op_code is left as is.
        if (!run) begin
            state_d    = ST_IDLE;
            pc_d       = '0;
            op_valid_d = 1'b0;
            mem_re     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            last_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            last_q     <= last_d;
            op_valid_q <= op_valid_d;
        end
    end

    prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (PC_WIDTH),
        .DW    (OP_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (mem_re),
        .rd_addr (mem_raddr),
        .rd_data (op_code)
    );

    assign pc       = pc_q;
    assign op_valid = op_valid_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, meaning number of instruction slots (fixed 16; PC is 4 bits).
REQ-002 SHALL have parameter OP_W, default 21, meaning opcode word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  1 = execute program, 0 = idle/load mode.
REQ-006 SHALL have port prog_we  input  1  program-memory write strobe, honoured only while run=0.
REQ-007 SHALL have port prog_addr  input  4  write address.
REQ-008 SHALL have port prog_data  input  21  opcode word written.
REQ-009 SHALL have port prog_len  input  5  number of valid instructions, 0..16, sampled while run=0.
REQ-010 SHALL have port pc_instr  input  4  PC control from the decoder: 0 NEXT, 1 JMP, 2 JEZ, 3 JNZ, 4 JGZ, 5 JLZ, 6 JRO; 7..15 treated as NEXT.
REQ-011 SHALL have port jmp_target  input  4  absolute target for JMP/Jcc (decoder const[3:0]).
REQ-012 SHALL have port jro_offset  input  11 signed  relative offset for JRO (selected source value).
REQ-013 SHALL have port acc  input  11 signed  accumulator value used for Jcc conditions.
REQ-014 SHALL have port stall  input  1  1 = current instruction blocked on a port; hold PC.
REQ-015 SHALL have port pc  output  4  address of the instruction presented on op_code.
REQ-016 SHALL have port op_code  output  21  registered instruction word, feeds op_decode.
REQ-017 SHALL have port op_valid  output  1  op_code is a live instruction to execute.

Function
REQ-018 SHALL implement states IDLE, START, RUN; IDLE->START when run=1 and prog_len!=0; START->RUN next cycle; any state->IDLE when run=0; IDLE holds when prog_len=0.
REQ-019 SHALL, in IDLE, write prog_data to mem[prog_addr] on prog_we, hold pc=0, op_valid=0, and latch last=prog_len-1.
REQ-020 SHALL, in START, load pc=0 and op_code=mem[0], asserting op_valid=1 from the following cycle.
REQ-021 SHALL, in RUN, compute pc_next and update pc<=pc_next and op_code<=mem[pc_next] on the same edge, so op_code always equals mem[pc] (1-cycle fetch latency).
REQ-022 SHALL hold pc and op_code unchanged when stall=1, regardless of pc_instr.
REQ-023 SHALL, for NEXT, set pc_next = pc+1, wrapping to 0 when pc==last.
REQ-024 SHALL, for JMP, set pc_next = jmp_target; a target greater than last SHALL give 0.
REQ-025 SHALL evaluate JEZ acc==0, JNZ acc!=0, JGZ acc>0, JLZ acc<0; taken -> as JMP, not taken -> as NEXT.
REQ-026 SHALL, for JRO, compute pc + jro_offset at 12-bit signed width and clamp to [0, last]; no wrap.
REQ-027 SHALL ignore prog_we while run=1; program memory contents are read-only during RUN.
REQ-028 SHALL, when run falls mid-instruction, drop op_valid on the next edge and return pc to 0.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state=IDLE, pc=0, op_code=0, op_valid=0, last=0.
REQ-030 SHALL leave program-memory contents undefined after reset (no clear).
REQ-031 SHALL, on reset release, require one clk edge in IDLE before START can be entered.

Structure
REQ-032 SHALL place pc_instr encodings, OP_W and PC width constants in the shared package tis_pkg, also used by op_decode.
REQ-033 SHALL instantiate one sub-module prog_mem (16x21, one sync write port, one registered read port).

Verification
REQ-034 SHALL cover: load 3 words, prog_len=3, run=1, pc_instr=NEXT -> pc sequence 0,1,2,0,1 with op_code matching written words.
REQ-035 SHALL cover: at pc=1 pc_instr=JRO, jro_offset=-5 -> pc=0; jro_offset=+9, last=2 -> pc=2.
REQ-036 SHALL cover: acc=0, JEZ target 2 -> pc=2; acc=-3, JGZ target 2 -> pc=pc+1; acc=-3, JLZ target 1 -> pc=1.
REQ-037 SHALL cover: stall=1 for 4 cycles with pc_instr=JMP target 0 at pc=2 -> pc stays 2; stall release -> pc=0 next edge.
REQ-038 SHALL cover: prog_len=0, run=1 -> op_valid stays 0, pc=0; prog_we during RUN -> memory unchanged.
REQ-039 SHALL cover: rst_n low mid-RUN between edges -> pc=0, op_valid=0 immediately, without waiting for clk.
